i_cache_fill_ctrl: RTL and testbench

I_CACHE_FILL_CTRL -- requirements
Module: i_cache_fill_ctrl

---
 rtl/i_cache_fill_ctrl_if.sv | 31 +++
 rtl/i_cache_fill_ctrl.sv | 98 +++++++++
 tb/tb_i_cache_fill_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i_cache_fill_ctrl_if.sv
// Bundle between the instruction-cache fill controller, the cache arrays and instruction memory.
// master is the controller side; slave is the cache/memory side.
interface i_cache_fill_ctrl_if #(
  parameter int unsigned CL_WIDTH          = 128,
  parameter int unsigned TAG_ADDRESS_WIDTH = 28
);
  logic                         miss_valid;
  logic [31:0]                  miss_address;
  logic [31:0]                  fill_requested_address;
  logic                         fill_requested_address_valid;
  logic                         rsp_valid;
  logic [31:0]                  rsp_address;
  logic [CL_WIDTH-1:0]          rsp_data;
  logic                         fill_valid;
  logic [TAG_ADDRESS_WIDTH-1:0] fill_tag;
  logic [CL_WIDTH-1:0]          fill_data;
  logic                         busy;
  logic                         timeout_err;

  modport master (
    input  miss_valid, miss_address, rsp_valid, rsp_address, rsp_data,
    output fill_requested_address, fill_requested_address_valid, fill_valid, fill_tag,
           fill_data, busy, timeout_err
  );

  modport slave (
    output miss_valid, miss_address, rsp_valid, rsp_address, rsp_data,
    input  fill_requested_address, fill_requested_address_valid, fill_valid, fill_tag,
           fill_data, busy, timeout_err
  );
endinterface

// File: rtl/i_cache_fill_ctrl.sv
// Instruction-cache line fill controller: requests a missing line, waits for the matching
// response (reissuing after a timeout) and writes it into the cache for one cycle.
module i_cache_fill_ctrl #(
  parameter int unsigned CL_WIDTH          = 128,
  parameter int unsigned TAG_ADDRESS_WIDTH = 28,
  parameter int unsigned TIMEOUT_CYCLES    = 32
) (
  input logic                clk,
  input logic                rst,
  i_cache_fill_ctrl_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StFill = 2'd3;

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

  logic [1:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [CL_WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic                rsp_match;
  logic                unused_addr_bits;

  // Memory echoes a byte address; only the line part identifies the response.
  assign rsp_match = (state_q == StWait) && bus.rsp_valid &&
                     (bus.rsp_address[31:4] == addr_q[31:4]);

  assign unused_addr_bits = ^{bus.rsp_address[3:0], bus.miss_address[3:0], addr_q[3:0]};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      StIdle: begin
        if (bus.miss_valid) begin
          addr_d  = {bus.miss_address[31:4], 4'b0000};
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A match on the final wait cycle takes priority over the reissue.
        if (rsp_match) begin
          data_d  = bus.rsp_data;
          state_d = StFill;
        end else if (cnt_q == CntLast) begin
          timeout_err_d = 1'b1;
          state_d       = StReq;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFill: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.fill_requested_address       = addr_q;
  assign bus.fill_requested_address_valid = (state_q == StReq);
  assign bus.fill_valid                   = (state_q == StFill);
  assign bus.fill_tag                     = addr_q[31:32-TAG_ADDRESS_WIDTH];
  assign bus.fill_data                    = data_q;
  assign bus.busy                         = (state_q != StIdle);
  assign bus.timeout_err                  = timeout_err_q;

endmodule

// File: tb/tb_i_cache_fill_ctrl.sv
// Self-checking bench for i_cache_fill_ctrl: cycle-time transaction model compared every cycle,
// plus literal expectations for each directed scenario.
module tb_i_cache_fill_ctrl;

  localparam int unsigned CLW = 128;
  localparam int unsigned TW  = 28;
  localparam int          T   = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  i_cache_fill_ctrl_if #(.CL_WIDTH(CLW), .TAG_ADDRESS_WIDTH(TW)) bus ();

  i_cache_fill_ctrl #(
    .CL_WIDTH         (CLW),
    .TAG_ADDRESS_WIDTH(TW),
    .TIMEOUT_CYCLES   (T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a fill is described by the cycle of its request pulse; the wait window is the T
  // cycles after the pulse, a match at cycle M fills at M+1, and the controller is idle at M+2.
  logic            m_pending = 1'b0;
  logic [31:0]     m_addr    = '0;
  logic [CLW-1:0]  m_data    = '0;
  logic            m_terr    = 1'b0;
  int              m_issue   = -1;
  int              m_fill    = -1;

  // Observed-event log used by the literal checks.
  int              pulse_cnt = 0, fill_cnt = 0;
  int              last_pulse_cyc = -1, last_fill_cyc = -1, idle_cyc = -1;
  logic [31:0]     last_pulse_addr = '0;
  logic [TW-1:0]   last_fill_tag = '0;
  logic [CLW-1:0]  last_fill_data = '0;
  logic            prev_busy = 1'b0;

  always @(negedge clk) begin
    logic exp_req, exp_fill;
    exp_req  = m_pending && (cyc == m_issue);
    exp_fill = m_pending && (cyc == m_fill);
    chk("busy", 128'(bus.busy), 128'(m_pending));
    chk("req_valid", 128'(bus.fill_requested_address_valid), 128'(exp_req));
    chk("fill_valid", 128'(bus.fill_valid), 128'(exp_fill));
    chk("req_addr", 128'(bus.fill_requested_address), 128'(m_addr));
    chk("timeout_err", 128'(bus.timeout_err), 128'(m_terr));
    if (exp_fill) begin
      chk("fill_tag", 128'(bus.fill_tag), 128'(m_addr[31:4]));
      chk("fill_data", 128'(bus.fill_data), 128'(m_data));
    end

    if (bus.fill_requested_address_valid) begin
      pulse_cnt++;
      last_pulse_cyc  = cyc;
      last_pulse_addr = bus.fill_requested_address;
    end
    if (bus.fill_valid) begin
      fill_cnt++;
      last_fill_cyc  = cyc;
      last_fill_tag  = bus.fill_tag;
      last_fill_data = bus.fill_data;
    end
    if (prev_busy && !bus.busy) idle_cyc = cyc;
    prev_busy = bus.busy;

    if (rst) begin
      m_pending = 1'b0;
      m_addr    = '0;
      m_data    = '0;
      m_terr    = 1'b0;
      m_fill    = -1;
    end else if (!m_pending) begin
      if (bus.miss_valid) begin
        m_pending = 1'b1;
        m_addr    = {bus.miss_address[31:4], 4'h0};
        m_issue   = cyc + 1;
        m_fill    = -1;
      end
    end else if (m_fill == cyc) begin
      m_pending = 1'b0;
    end else if (m_fill < 0 && cyc > m_issue) begin
      if (bus.rsp_valid && bus.rsp_address[31:4] == m_addr[31:4]) begin
        m_data = bus.rsp_data;
        m_fill = cyc + 1;
      end else if (cyc == m_issue + T) begin
        m_issue = cyc + 1;
        m_terr  = 1'b1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic miss(input logic [31:0] a);
    bus.miss_valid   = 1'b1;
    bus.miss_address = a;
    step();
    bus.miss_valid   = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] a, input logic [CLW-1:0] d);
    bus.rsp_valid   = 1'b1;
    bus.rsp_address = a;
    bus.rsp_data    = d;
    step();
    bus.rsp_valid   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p0, f0;
    rst              = 1'b1;
    bus.miss_valid   = 1'b0;
    bus.miss_address = '0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_address  = '0;
    bus.rsp_data     = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_req_valid", 128'(bus.fill_requested_address_valid), 128'(0));
    chk("rst_fill_valid", 128'(bus.fill_valid), 128'(0));
    chk("rst_req_addr", 128'(bus.fill_requested_address), 128'(0));
    step();

    // Basic fill, memory latency 8.
    c0 = cyc; p0 = pulse_cnt; f0 = fill_cnt;
    miss(32'h0000_1234);
    goto(c0 + 9);
    rsp(32'h0000_1230, {16{8'hA5}});
    goto(c0 + 13);
    chk("s1_pulse_cyc", 128'(last_pulse_cyc - c0), 128'(1));
    chk("s1_pulse_addr", 128'(last_pulse_addr), 128'(32'h0000_1230));
    chk("s1_fill_cyc", 128'(last_fill_cyc - c0), 128'(10));
    chk("s1_fill_tag", 128'(last_fill_tag), 128'(28'h000_0123));
    chk("s1_fill_data", last_fill_data, {16{8'hA5}});
    chk("s1_idle_cyc", 128'(idle_cyc - c0), 128'(11));
    chk("s1_pulses", 128'(pulse_cnt - p0), 128'(1));
    chk("s1_fills", 128'(fill_cnt - f0), 128'(1));

    // Mismatched response ignored, later matching one fills.
    c0 = cyc; f0 = fill_cnt;
    miss(32'h0000_1238);
    goto(c0 + 4);
    rsp(32'h0000_2000, {8{16'hDEAD}});
    goto(c0 + 7);
    rsp(32'h0000_123C, {16{8'h5A}});
    goto(c0 + 11);
    chk("s2_fill_cyc", 128'(last_fill_cyc - c0), 128'(8));
    chk("s2_fill_data", last_fill_data, {16{8'h5A}});
    chk("s2_fills", 128'(fill_cnt - f0), 128'(1));

    // Timeout and reissue, then late fill; error stays set.
    c0 = cyc; p0 = pulse_cnt; f0 = fill_cnt;
    miss(32'h0000_3004);
    goto(c0 + 40);
    chk("s3_pulses", 128'(pulse_cnt - p0), 128'(2));
    chk("s3_reissue_cyc", 128'(last_pulse_cyc - c0), 128'(34));
    chk("s3_reissue_addr", 128'(last_pulse_addr), 128'(32'h0000_3000));
    chk("s3_terr", 128'(bus.timeout_err), 128'(1));
    rsp(32'h0000_3000, {4{32'hCAFE_F00D}});
    goto(c0 + 44);
    chk("s3_fill_cyc", 128'(last_fill_cyc - c0), 128'(41));
    chk("s3_terr_after", 128'(bus.timeout_err), 128'(1));

    // miss_valid held through a fill; new address accepted only in the first idle cycle.
    c0 = cyc; p0 = pulse_cnt;
    bus.miss_valid   = 1'b1;
    bus.miss_address = 32'h0000_1230;
    step();
    bus.miss_address = 32'h0000_1FF0;
    goto(c0 + 5);
    rsp(32'h0000_1230, {16{8'h11}});
    goto(c0 + 7);
    chk("s4_pulses_busy", 128'(pulse_cnt - p0), 128'(1));
    bus.miss_address = 32'h0000_2044;
    step();
    bus.miss_valid = 1'b0;
    goto(c0 + 12);
    rsp(32'h0000_2040, {16{8'h22}});
    goto(c0 + 16);
    chk("s4_pulse_cyc", 128'(last_pulse_cyc - c0), 128'(8));
    chk("s4_pulse_addr", 128'(last_pulse_addr), 128'(32'h0000_2040));
    chk("s4_fill_data", last_fill_data, {16{8'h22}});
    chk("s4_terr_sticky", 128'(bus.timeout_err), 128'(1));

    // Reset while waiting; stale response afterwards is ignored.
    c0 = cyc; f0 = fill_cnt;
    miss(32'h0000_5678);
    goto(c0 + 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    goto(c0 + 9);
    rsp(32'h0000_5670, {16{8'h77}});
    goto(c0 + 14);
    chk("s5_fills", 128'(fill_cnt - f0), 128'(0));
    chk("s5_busy", 128'(bus.busy), 128'(0));
    chk("s5_req_addr", 128'(bus.fill_requested_address), 128'(0));
    chk("s5_terr", 128'(bus.timeout_err), 128'(0));

    // Match on the timeout cycle wins over the reissue.
    c0 = cyc; p0 = pulse_cnt;
    miss(32'h0000_7008);
    goto(c0 + 33);
    rsp(32'h0000_7000, {16{8'h3C}});
    goto(c0 + 37);
    chk("s6_pulses", 128'(pulse_cnt - p0), 128'(1));
    chk("s6_fill_cyc", 128'(last_fill_cyc - c0), 128'(34));
    chk("s6_fill_data", last_fill_data, {16{8'h3C}});
    chk("s6_terr", 128'(bus.timeout_err), 128'(0));

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
